// File: rtl/game_tick_pkg.sv
// Shared defaults and width helper for the game tick generator.
package game_tick_pkg;

  localparam int NUM_CH_D     = 2;
  localparam int CNT_W_D      = 32;
  localparam int DEF_PERIOD_D = 10_000_000;
  localparam int MIN_PERIOD_D = 1;
  localparam int STEP_D       = 500_000;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: period register, down-counter and registered tick/at_min.
module tick_channel #(
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 10_000_000,
  parameter int MIN_PERIOD = 1,
  parameter int STEP       = 500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             restart,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  input  logic             speed_up,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             at_min
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  // Speed-up is only a plain subtraction above this bound; widened so it cannot wrap.
  localparam logic [CNT_W+1:0] FLOOR = (CNT_W+2)'(MIN_PERIOD) + (CNT_W+2)'(STEP);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] p_wr;
  logic [CNT_W-1:0] p_next;

  always_comb begin
    p_wr   = period;
    p_next = period;
    if (we) begin
      p_wr   = (wdata < MIN_P) ? MIN_P : wdata;
      p_next = p_wr;
    end else if (speed_up && !pause) begin
      p_next = ({2'b00, period} > FLOOR) ? period - CNT_W'(STEP) : MIN_P;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period <= DEF_P;
      cnt    <= DEF_P - CNT_W'(1);
      tick   <= 1'b0;
      at_min <= (DEF_P == MIN_P);
    end else begin
      period <= p_next;
      at_min <= (p_next == MIN_P);
      if (restart || we) begin
        cnt  <= p_wr - CNT_W'(1);
        tick <= 1'b0;
      end else if (pause) begin
        tick <= 1'b0;
      end else if (cnt == '0) begin
        cnt  <= period - CNT_W'(1);
        tick <= 1'b1;
      end else begin
        cnt  <= cnt - CNT_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/game_tick_gen.sv
// Multi-channel game tick generator: decodes period writes and packs channel outputs.
module game_tick_gen
  import game_tick_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_D,
  parameter int CNT_W      = CNT_W_D,
  parameter int DEF_PERIOD = DEF_PERIOD_D,
  parameter int MIN_PERIOD = MIN_PERIOD_D,
  parameter int STEP       = STEP_D
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  input  logic                        restart,
  input  logic                        period_we,
  input  logic [clog2_min1(NUM_CH)-1:0] period_ch,
  input  logic [CNT_W-1:0]            period_wdata,
  input  logic [NUM_CH-1:0]           speed_up,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH*CNT_W-1:0]     period_out,
  output logic [NUM_CH-1:0]           at_min
);

  localparam int CH_W = clog2_min1(NUM_CH);

  if (MIN_PERIOD < 1) begin : g_bad_min
    $error("game_tick_gen: MIN_PERIOD must be at least 1");
  end
  if (DEF_PERIOD < MIN_PERIOD) begin : g_bad_def
    $error("game_tick_gen: DEF_PERIOD must not be below MIN_PERIOD");
  end
  if ((CNT_W < 31) && (DEF_PERIOD >= (1 << CNT_W))) begin : g_bad_width
    $error("game_tick_gen: DEF_PERIOD does not fit in CNT_W bits");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_hit;
    // Out-of-range channel indices never match, so those writes drop out here.
    assign we_hit = period_we && (period_ch == CH_W'(i));

    tick_channel #(
      .CNT_W     (CNT_W),
      .DEF_PERIOD(DEF_PERIOD),
      .MIN_PERIOD(MIN_PERIOD),
      .STEP      (STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .pause   (pause),
      .restart (restart),
      .we      (we_hit),
      .wdata   (period_wdata),
      .speed_up(speed_up[i]),
      .tick    (tick[i]),
      .period  (period_out[i*CNT_W +: CNT_W]),
      .at_min  (at_min[i])
    );
  end

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen with small parameters; tick masks are hand-derived per scenario.
module tb_game_tick_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pause = 1'b0;
  logic              restart = 1'b0;
  logic              period_we = 1'b0;
  logic [0:0]        period_ch = '0;
  logic [CNT_W-1:0]  period_wdata = '0;
  logic [NUM_CH-1:0] speed_up = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH*CNT_W-1:0] period_out;
  logic [NUM_CH-1:0] at_min;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] m0 = '0;
  logic [63:0] m1 = '0;

  game_tick_gen #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .DEF_PERIOD(8),
    .MIN_PERIOD(2),
    .STEP      (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .restart     (restart),
    .period_we   (period_we),
    .period_ch   (period_ch),
    .period_wdata(period_wdata),
    .speed_up    (speed_up),
    .tick        (tick),
    .period_out  (period_out),
    .at_min      (at_min)
  );

  always #5 clk = ~clk;

  // One clock edge, then compare tick against the scenario masks for this cycle.
  task automatic step();
    logic [1:0] exp;
    @(posedge clk);
    #1;
    cyc++;
    exp = {m1[cyc], m0[cyc]};
    checks++;
    assert (tick === exp) else begin
      errors++;
      $error("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, exp);
    end
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset(input logic [63:0] new_m0, input logic [63:0] new_m1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_period", 32'(period_out), 32'h0808);
    chk("rst_at_min", 32'(at_min), 32'd0);
    rst = 1'b0;
    cyc = 0;
    m0 = new_m0;
    m1 = new_m1;
  endtask

  initial begin
    // Free running: ticks at 8, 16, 24 on both channels.
    do_reset(64'h0101_0100, 64'h0101_0100);
    run_to(26);

    // Speed-ups on ch0 at 3, 14 and 16: P 8 -> 5 -> 2 -> 2.
    do_reset(64'h0154_2100, 64'h0101_0100);
    run_to(2);
    speed_up = 2'b01; step(); speed_up = '0;
    chk("su1_period0", 32'(period_out[7:0]), 32'd5);
    chk("su1_at_min", 32'(at_min), 32'd0);
    run_to(13);
    speed_up = 2'b01; step(); speed_up = '0;
    chk("su2_period0", 32'(period_out[7:0]), 32'd2);
    chk("su2_at_min", 32'(at_min), 32'b01);
    run_to(15);
    speed_up = 2'b01; step(); speed_up = '0;
    chk("su3_period0", 32'(period_out[7:0]), 32'd2);
    chk("su3_period1", 32'(period_out[15:8]), 32'd8);
    run_to(24);

    // Pause over cycles 5-9, with a ch1 write of 4 accepted at cycle 7.
    do_reset(64'h0020_2000, 64'h0022_2000);
    run_to(4);
    pause = 1'b1;
    run_to(6);
    period_we = 1'b1; period_ch = 1'b1; period_wdata = 8'd4;
    step();
    period_we = 1'b0;
    chk("pause_wr_period1", 32'(period_out[15:8]), 32'd4);
    run_to(9);
    pause = 1'b0;
    run_to(22);

    // ch1 write of 1 clamps to 2 with speed_up dropped; ch0 write of 6 at 13 wins over speed_up.
    do_reset(64'h0008_0100, 64'h0015_5540);
    run_to(3);
    period_we = 1'b1; period_ch = 1'b1; period_wdata = 8'd1; speed_up = 2'b10;
    step();
    period_we = 1'b0; speed_up = '0;
    chk("wr1_period1", 32'(period_out[15:8]), 32'd2);
    chk("wr1_at_min", 32'(at_min), 32'b10);
    run_to(12);
    period_we = 1'b1; period_ch = 1'b0; period_wdata = 8'd6; speed_up = 2'b01;
    step();
    period_we = 1'b0; speed_up = '0;
    chk("wr0_period0", 32'(period_out[7:0]), 32'd6);
    chk("wr0_at_min", 32'(at_min), 32'b10);
    run_to(20);

    // Restart at cycle 6 realigns both channels to tick at 14 and 22.
    do_reset(64'h0040_4000, 64'h0040_4000);
    run_to(5);
    restart = 1'b1; step(); restart = 1'b0;
    run_to(22);

    // Reset mid-count at cycle 10 after a speed-up: state discarded, next tick at 18.
    do_reset(64'h0404_0100, 64'h0404_0100);
    run_to(8);
    speed_up = 2'b11; step(); speed_up = '0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_period", 32'(period_out), 32'h0808);
    chk("midrst_at_min", 32'(at_min), 32'd0);
    run_to(27);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
